// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: emits one 802.15.4 PPDU (SHR, PHR, PSDU) to the
// modulator over a valid/ready byte handshake, popping payload from the TX FIFO.
`timescale 1ns/1ps
module tx_frame_sequencer #(
    parameter int         MAX_PSDU       = 127,
    parameter int         PREAMBLE_BYTES = 4,
    parameter logic [7:0] SFD_BYTE       = 8'hA7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [6:0] tx_len,
    input  logic [8:0] fifo_count,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic [7:0] mod_data,
    output logic       mod_valid,
    input  logic       mod_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [2:0] seq_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SFD   = 3'd2;
    localparam logic [2:0] S_PHR   = 3'd3;
    localparam logic [2:0] S_FETCH = 3'd4;
    localparam logic [2:0] S_LOAD  = 3'd5;
    localparam logic [2:0] S_SEND  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int PW = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BYTES - 1);

    logic [2:0]    state;
    logic [6:0]    remaining;
    logic [6:0]    len_q;
    logic [PW-1:0] pre_cnt;
    logic          hs;
    logic          start_ok;
    logic          fifo_empty;

    assign hs         = mod_valid & mod_ready;
    assign fifo_empty = (fifo_count == 9'd0);
    assign seq_state  = state;

    always_comb begin
        start_ok = (tx_len != 7'd0)
                && ({1'b0, tx_len} <= 8'(MAX_PSDU))
                && (fifo_count >= {2'b00, tx_len});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            len_q     <= '0;
            pre_cnt   <= '0;
            mod_data  <= 8'h00;
            mod_valid <= 1'b0;
            fifo_rd   <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            fifo_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        if (!start_ok) begin
                            tx_err <= 1'b1;
                        end else begin
                            len_q     <= tx_len;
                            remaining <= tx_len;
                            pre_cnt   <= '0;
                            mod_data  <= 8'h00;
                            mod_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (hs) begin
                        pre_cnt <= pre_cnt + PW'(1);
                        if (pre_cnt == PRE_LAST) begin
                            mod_data <= SFD_BYTE;
                            state    <= S_SFD;
                        end
                    end
                end
                S_SFD: begin
                    if (hs) begin
                        mod_data <= {1'b0, len_q};
                        state    <= S_PHR;
                    end
                end
                S_PHR: begin
                    if (hs) begin
                        // FIFO occupancy is judged on the way into FETCH
                        mod_valid <= 1'b0;
                        state     <= S_FETCH;
                        fifo_rd   <= !fifo_empty;
                        tx_err    <= fifo_empty;
                    end
                end
                S_FETCH: begin
                    if (fifo_rd) begin
                        state <= S_LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    mod_data  <= fifo_data;
                    mod_valid <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        mod_valid <= 1'b0;
                        remaining <= remaining - 7'd1;
                        if (remaining == 7'd1) begin
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_FETCH;
                            fifo_rd <= !fifo_empty;
                            tx_err  <= fifo_empty;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: directed frames against a byte-array FIFO model,
// with a negedge monitor collecting the handshaked stream and strobe timing.
`timescale 1ns/1ps
module tb_tx_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [6:0] tx_len = '0;
    logic [8:0] fifo_count;
    logic       fifo_rd;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] mod_data;
    logic       mod_valid;
    logic       mod_ready = 1'b1;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic [2:0] seq_state;

    logic       b_start = 1'b0;
    logic       b_rd;
    logic [7:0] b_data;
    logic       b_v;
    logic       b_busy;
    logic       b_done;
    logic       b_err;
    logic [2:0] b_state;

    always #5 clk = ~clk;

    tx_frame_sequencer u_dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_len(tx_len),
        .fifo_count(fifo_count), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
        .mod_data(mod_data), .mod_valid(mod_valid), .mod_ready(mod_ready),
        .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
        .seq_state(seq_state)
    );

    tx_frame_sequencer #(.MAX_PSDU(100)) u_dut100 (
        .clk(clk), .reset(reset), .tx_start(b_start), .tx_len(tx_len),
        .fifo_count(9'd200), .fifo_rd(b_rd), .fifo_data(8'h00),
        .mod_data(b_data), .mod_valid(b_v), .mod_ready(1'b1),
        .busy(b_busy), .tx_done(b_done), .tx_err(b_err),
        .seq_state(b_state)
    );

    logic [7:0] mem [256];
    logic [7:0] exp_pl [128];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       ov_en = 1'b0;
    logic [8:0] ov_val = '0;

    assign fifo_count = ov_en ? ov_val : 9'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[8'(rd_ptr)];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic [7:0] stream [$];
    int rd_n = 0, done_n = 0, err_n = 0, mv_n = 0, busy_n = 0;
    int stab_bad = 0, rd_bad = 0;
    int done_at = -1, err_at = -1, fall_at = -1;
    int b_err_n = 0, b_rd_n = 0, b_mv_n = 0;
    logic pv = 1'b0, phs = 1'b0, prst = 1'b1, pb = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(negedge clk) begin
        if (mod_valid && mod_ready) stream.push_back(mod_data);
        if (fifo_rd) rd_n <= rd_n + 1;
        if (fifo_rd && fifo_count == 9'd0) rd_bad <= rd_bad + 1;
        if (tx_done) begin
            done_n  <= done_n + 1;
            done_at <= ecnt;
        end
        if (tx_err) begin
            err_n  <= err_n + 1;
            err_at <= ecnt;
        end
        if (mod_valid) mv_n <= mv_n + 1;
        if (busy) busy_n <= busy_n + 1;
        if (!busy && pb) fall_at <= ecnt;
        if (pv && !phs && !prst && (!mod_valid || mod_data !== pd))
            stab_bad <= stab_bad + 1;
        if (b_err) b_err_n <= b_err_n + 1;
        if (b_rd) b_rd_n <= b_rd_n + 1;
        if (b_v) b_mv_n <= b_mv_n + 1;
        pv   <= mod_valid;
        pd   <= mod_data;
        phs  <= mod_valid && mod_ready;
        prst <= reset;
        pb   <= busy;
    end

    int total = 0;
    int bad = 0;
    int t0 = 0;
    int s_base = 0, rd_b = 0, done_b = 0, err_b = 0, mv_b = 0, busy_b = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cyc(input int at);
        return at - t0 + 1;
    endfunction

    task automatic load_seq(input int n, input int first);
        wr_ptr = rd_ptr;
        for (int k = 0; k < n; k++) begin
            exp_pl[k]        = 8'(first + k);
            mem[8'(wr_ptr)]  = 8'(first + k);
            wr_ptr           = wr_ptr + 1;
        end
    endtask

    task automatic start(input logic [6:0] len);
        @(posedge clk); #1;
        s_base = stream.size();
        rd_b   = rd_n;
        done_b = done_n;
        err_b  = err_n;
        mv_b   = mv_n;
        busy_b = busy_n;
        tx_start = 1'b1;
        tx_len   = len;
        @(posedge clk); #1;
        tx_start = 1'b0;
        t0 = ecnt;
    endtask

    task automatic chk_stream(input string tag, input int n);
        int nb;
        logic [7:0] e;
        nb = 0;
        chk({tag, "_len"}, stream.size() - s_base, n + 6);
        for (int i = 0; i < n + 6 && s_base + i < stream.size(); i++) begin
            if (i < 4)       e = 8'h00;
            else if (i == 4) e = 8'hA7;
            else if (i == 5) e = 8'(n);
            else             e = exp_pl[i-6];
            if (stream[s_base+i] !== e) nb++;
        end
        chk({tag, "_bytes"}, nb, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", seq_state, 0);
        chk("rst_valid", mod_valid, 0);
        chk("rst_data", mod_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {fifo_rd, tx_done, tx_err}, 0);
        reset = 1'b0;

        // nominal 3-byte frame
        load_seq(3, 1);
        start(3);
        chk("nom_c1", {seq_state, busy, mod_valid}, {3'd1, 1'b1, 1'b1});
        repeat (25) @(posedge clk);
        #1;
        chk_stream("nom", 3);
        chk("nom_rd", rd_n - rd_b, 3);
        chk("nom_done_n", done_n - done_b, 1);
        chk("nom_done_cyc", cyc(done_at), 16);
        chk("nom_idle_cyc", cyc(fall_at), 17);
        chk("nom_err", err_n - err_b, 0);

        // backpressure: 5 cycles in SFD, 2 in payload byte 1
        load_seq(3, 1);
        start(3);
        repeat (4) @(posedge clk);
        #1 mod_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 mod_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 mod_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 mod_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_stream("bp", 3);
        chk("bp_done_cyc", cyc(done_at), 23);
        chk("bp_rd", rd_n - rd_b, 3);
        chk("bp_stable", stab_bad, 0);

        // rejections
        start(0);
        repeat (5) @(posedge clk);
        #1;
        chk("rej0_err", err_n - err_b, 1);
        chk("rej0_cyc", cyc(err_at), 1);
        chk("rej0_quiet", {rd_n - rd_b, mv_n - mv_b, busy_n - busy_b}, 0);
        ov_en = 1'b1;
        ov_val = 9'd5;
        start(8);
        repeat (5) @(posedge clk);
        #1;
        chk("rej8_err", err_n - err_b, 1);
        chk("rej8_quiet", {rd_n - rd_b, mv_n - mv_b, busy_n - busy_b}, 0);
        ov_en = 1'b0;
        @(posedge clk); #1;
        b_start = 1'b1;
        tx_len  = 7'd127;
        @(posedge clk); #1;
        b_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rej127_err", b_err_n, 1);
        chk("rej127_quiet", {b_rd_n, b_mv_n}, 0);

        // maximum length
        load_seq(127, 0);
        start(127);
        repeat (400) @(posedge clk);
        #1;
        chk_stream("max", 127);
        chk("max_rd", rd_n - rd_b, 127);
        chk("max_done_cyc", cyc(done_at), 388);

        // underrun before third FETCH
        load_seq(4, 8'h40);
        start(4);
        repeat (10) @(posedge clk);
        #1;
        ov_en  = 1'b1;
        ov_val = 9'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("ur_err", err_n - err_b, 1);
        chk("ur_err_cyc", cyc(err_at), 13);
        chk("ur_rd", rd_n - rd_b, 2);
        chk("ur_done", done_n - done_b, 0);
        chk("ur_idle", {seq_state, busy}, 0);
        chk("ur_stream", stream.size() - s_base, 8);
        ov_en = 1'b0;

        // reset during payload SEND
        load_seq(2, 8'h11);
        start(2);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_in_send", seq_state, 6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst", {seq_state, busy, mod_valid, fifo_rd}, 0);

        // stray start during preamble is ignored
        load_seq(3, 8'h0A);
        start(3);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_len   = 7'd0;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk_stream("stray", 3);
        chk("stray_done_cyc", cyc(done_at), 16);
        chk("stray_err", err_n - err_b, 0);
        chk("rd_when_empty", rd_bad, 0);
        chk("stable_all", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
